// File: rtl/clb_config_loader.sv
// Serial configuration-chain sequencer: pulls bitstream words and shifts them LSB-first into a CLB chain.
// Latency: 2*CLK_DIV clk per bit plus one FETCH cycle per word and one FINISH cycle per pass.
// Backpressure: stalls in FETCH (config_clk low, config_en held) until word_valid; no timeout.
// Optional feature macro: READBACK_CHECK_EN (double pass with CRC-16 readback compare).
module clb_config_loader #(
    parameter int CHAIN_LEN = 267,
    parameter int WORD_W    = 32,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_clk,
    output logic              config_en,
    output logic              config_in,
    input  logic              config_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WCW = $clog2(WORD_W + 1);
    localparam int DCW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        FINISH
    } state_t;

    state_t            state;
    logic [DCW-1:0]    div_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [WCW-1:0]    wbit_cnt;
    logic [WORD_W-1:0] sreg;

    logic              div_last;
    logic [BCW-1:0]    bit_nxt;
    logic [WCW-1:0]    wbit_nxt;
    logic              pass_end;
    logic              word_end;
    logic [WORD_W-1:0] sreg_shift;

    assign div_last   = (div_cnt == DCW'(CLK_DIV - 1));
    assign bit_nxt    = bit_cnt + BCW'(1);
    assign wbit_nxt   = wbit_cnt + WCW'(1);
    assign pass_end   = (bit_nxt == BCW'(CHAIN_LEN));
    assign word_end   = (wbit_nxt == WCW'(WORD_W));
    assign sreg_shift = sreg >> 1;

`ifdef READBACK_CHECK_EN
    // Pass one is the real load; pass two pushes the same stream again while
    // the tail is read back, so the chain ends with the same contents.
    logic        pass;
    logic [15:0] crc_tx;
    logic [15:0] crc_rx;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
`endif

    // Sequencer FSM; every output is a register so the chain sees glitch-free clock/enable/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            wbit_cnt   <= '0;
            sreg       <= '0;
            word_ready <= 1'b0;
            config_clk <= 1'b0;
            config_en  <= 1'b0;
            config_in  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef READBACK_CHECK_EN
            pass       <= 1'b0;
            crc_tx     <= 16'hFFFF;
            crc_rx     <= 16'hFFFF;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    config_clk <= 1'b0;
                    config_en  <= 1'b0;
                    config_in  <= 1'b0;
                    word_ready <= 1'b0;
                    busy       <= 1'b0;
                    if (start) begin
                        error      <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        wbit_cnt   <= '0;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                        state      <= FETCH;
`ifdef READBACK_CHECK_EN
                        pass       <= 1'b0;
                        crc_tx     <= 16'hFFFF;
                        crc_rx     <= 16'hFFFF;
`endif
                    end
                end

                // Wait for a word; config_en keeps its value so a stall does not drop enable.
                FETCH: begin
                    config_clk <= 1'b0;
                    if (word_valid && word_ready) begin
                        sreg       <= word_data;
                        config_in  <= word_data[0];
                        config_en  <= 1'b1;
                        word_ready <= 1'b0;
                        div_cnt    <= '0;
                        state      <= LOW;
                    end
                end

                // Data setup half; readback samples the tail just before the rising edge.
                LOW: begin
                    if (div_last) begin
                        div_cnt    <= '0;
                        config_clk <= 1'b1;
                        state      <= HIGH;
`ifdef READBACK_CHECK_EN
                        if (pass) crc_rx <= crc16_step(crc_rx, config_out);
`endif
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                // Capture half; the bit is retired at the end of it.
                HIGH: begin
                    if (div_last) begin
                        div_cnt    <= '0;
                        sreg       <= sreg_shift;
                        config_clk <= 1'b0;
                        bit_cnt    <= bit_nxt;
`ifdef READBACK_CHECK_EN
                        if (!pass) crc_tx <= crc16_step(crc_tx, config_in);
`endif
                        if (pass_end) begin
`ifdef READBACK_CHECK_EN
                            if (!pass) begin
                                pass       <= 1'b1;
                                bit_cnt    <= '0;
                                wbit_cnt   <= '0;
                                word_ready <= 1'b1;
                                state      <= FETCH;
                            end else begin
                                config_en <= 1'b0;
                                config_in <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                error     <= (crc_tx != crc_rx);
                                state     <= FINISH;
                            end
`else
                            config_en <= 1'b0;
                            config_in <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
`endif
                        end else if (word_end) begin
                            wbit_cnt   <= '0;
                            word_ready <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            wbit_cnt  <= wbit_nxt;
                            config_in <= sreg_shift[0];
                            state     <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                // Outputs already parked at idle values on entry; done is high this cycle only.
                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader: behavioural chain model, edge/done counters, stall source.
// Covers reset state, plain load, source stall, ignored restart, async reset mid-pass, CLK_DIV=1 timing.
// Optional READBACK_CHECK_EN build adds the short-chain error case and sticky error behaviour.
module tb_clb_config_loader;

    localparam int L  = 267;
    localparam int W  = 32;
    localparam int D  = 2;
    localparam int NW = 9;
    localparam int L2 = 64;
`ifdef READBACK_CHECK_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [W-1:0]  word_data;
    logic          word_valid;
    logic          word_ready;
    logic          config_clk;
    logic          config_en;
    logic          config_in;
    logic          config_out;
    logic          busy;
    logic          done;
    logic          error;

    logic          start2;
    logic [W-1:0]  word_data2;
    logic          word_valid2;
    logic          word_ready2;
    logic          config_clk2;
    logic          config_en2;
    logic          config_in2;
    logic          config_out2;
    logic          busy2;
    logic          done2;
    logic          error2;

    clb_config_loader #(.CHAIN_LEN(L), .WORD_W(W), .CLK_DIV(D)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .config_clk (config_clk),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    clb_config_loader #(.CHAIN_LEN(L2), .WORD_W(W), .CLK_DIV(1)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .word_data  (word_data2),
        .word_valid (word_valid2),
        .word_ready (word_ready2),
        .config_clk (config_clk2),
        .config_en  (config_en2),
        .config_in  (config_in2),
        .config_out (config_out2),
        .busy       (busy2),
        .done       (done2),
        .error      (error2)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Bitstream: word 0 all zero, bit 266 (word 8 bit 10) set, word 8 bit 11+ junk to be discarded.
    logic [W-1:0] words [NW] = '{32'h0000_0000, 32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF,
                                 32'h0F0F_0F0F, 32'hCAFE_F00D, 32'h5555_AAAA, 32'hFFFF_0000,
                                 32'hABCD_ED55};
    logic [W-1:0] words2 [2] = '{32'hF00D_1234, 32'h8765_4321};
    logic [L-1:0]  exp_chain;
    logic [L2-1:0] exp_chain2;

    // Behavioural chains: stage 0 is the head, top index is the tail.
    logic [L-1:0]  chain  = '0;
    logic [L2-1:0] chain2 = '0;
    logic          short_chain = 1'b0;
    int edge_cnt = 0, done_cnt = 0, stall_cyc = 0, stall_bad = 0;
    int rises2 = 0, tog2 = 0, act2 = 0;
    logic cclk2_q = 1'b0;

    always @(posedge config_clk) begin
        edge_cnt <= edge_cnt + 1;
        if (config_en) chain <= {chain[L-2:0], config_in};
    end
    assign config_out = short_chain ? chain[L-2] : chain[L-1];

    always @(posedge config_clk2) begin
        rises2 <= rises2 + 1;
        if (config_en2) chain2 <= {chain2[L2-2:0], config_in2};
    end
    assign config_out2 = chain2[L2-1];

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    always @(negedge clk) begin
        if (busy && word_ready && !word_valid) begin
            stall_cyc <= stall_cyc + 1;
            if (config_clk !== 1'b0 || config_en !== 1'b1) stall_bad <= stall_bad + 1;
        end
        if (config_clk2 !== cclk2_q) tog2 <= tog2 + 1;
        cclk2_q <= config_clk2;
        if (busy2 || done2) act2 <= act2 + 1;
    end

    // Word source for the main DUT; a new src_gen restarts it from word 0.
    int src_gen = 0;
    int stall_at = -1;
    int idx = 0, last_gen = 0, stall_cnt = 0;
    bit stall_done = 1'b0;
    initial begin
        word_valid = 1'b0;
        word_data  = '0;
        forever begin
            @(posedge clk);
            if (src_gen != last_gen) begin
                last_gen   = src_gen;
                idx        = 0;
                stall_cnt  = 0;
                stall_done = 1'b0;
            end else if (word_valid && word_ready) begin
                idx++;
            end
            if (idx == stall_at && !stall_done && word_ready && !word_valid) begin
                stall_cnt++;
                if (stall_cnt >= 10) stall_done = 1'b1;
            end
            #1;
            word_valid = (idx < NW * REP) && !(idx == stall_at && !stall_done);
            word_data  = words[idx % NW];
        end
    end

    // Always-valid source for the CLK_DIV=1 instance.
    int idx2 = 0;
    initial begin
        word_valid2 = 1'b1;
        word_data2  = words2[0];
        forever begin
            @(posedge clk);
            if (word_valid2 && word_ready2) idx2++;
            #1;
            word_data2 = words2[idx2 % 2];
        end
    end

    task automatic run_pass(input string tag, input int stall, input bit restart, input logic exp_err);
        int e0, d0, s0, sb0, cyc, bad;
        bit restarted;
        e0 = edge_cnt; d0 = done_cnt; s0 = stall_cyc; sb0 = stall_bad;
        restarted = 1'b0;
        @(negedge clk);
        stall_at = stall;
        src_gen++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (restart && !restarted && (edge_cnt - e0) >= 100) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++;
                restarted = 1'b1;
            end
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_fin"}, busy, 0);
        check({tag, "_err"}, error, exp_err);
        repeat (3) @(negedge clk);
        check({tag, "_edges"}, edge_cnt - e0, L * REP);
        check({tag, "_dones"}, done_cnt - d0, 1);
        check({tag, "_en_off"}, config_en, 0);
        bad = 0;
        for (int k = 0; k < L; k++) if (chain[k] !== exp_chain[k]) bad++;
        check({tag, "_chain"}, bad, 0);
        if (stall >= 0) begin
            check({tag, "_stall_cyc"}, stall_cyc - s0, 10);
            check({tag, "_stall_hold"}, stall_bad - sb0, 0);
        end
    endtask

    initial begin
        int e0, cyc, bad, r0, t0, a0;
        for (int k = 0; k < L; k++) exp_chain[L-1-k] = words[k / W][k % W];
        for (int k = 0; k < L2; k++) exp_chain2[L2-1-k] = words2[k / W][k % W];

        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        #12;
        check("reset_outs", {config_clk, config_en, config_in, word_ready, busy, done, error}, 7'b0);
        check("reset_outs2", {config_clk2, config_en2, config_in2, word_ready2, busy2, done2, error2}, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outs", {config_clk, config_en, word_ready, busy, done}, 5'b0);

        run_pass("plain", -1, 1'b0, 1'b0);
        run_pass("stall", 4, 1'b0, 1'b0);
        run_pass("restart", -1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a pass.
        @(negedge clk);
        src_gen++;
        stall_at = -1;
        e0 = edge_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while ((edge_cnt - e0) < 150 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_150", ((edge_cnt - e0) >= 150), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {config_clk, config_en, config_in, word_ready, busy, done, error}, 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_pass("after_rst", -1, 1'b0, 1'b0);

        // CLK_DIV=1, 64-bit chain: config_clk toggles every clk.
        r0 = rises2; t0 = tog2; a0 = act2;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("div1_done_seen", done2, 1);
        repeat (3) @(negedge clk);
        check("div1_rises", rises2 - r0, L2 * REP);
        check("div1_toggles", tog2 - t0, 2 * L2 * REP);
        check("div1_cycles", act2 - a0, (2 * L2 + 2) * REP + 1);
        bad = 0;
        for (int k = 0; k < L2; k++) if (chain2[k] !== exp_chain2[k]) bad++;
        check("div1_chain", bad, 0);
        check("div1_err", error2, 0);

`ifdef READBACK_CHECK_EN
        short_chain = 1'b1;
        run_pass("rb_short", -1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("rb_err_sticky", error, 1);
        short_chain = 1'b0;
        run_pass("rb_good", -1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
